// File: rtl/axis_pair_tx_if.sv
// Operand-pair load port plus AXI-Stream master port of axis_pair_tx.
// master = transmitter view, slave = producer/sink environment view.
interface axis_pair_tx_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]          data1_i;
    logic [WIDTH-1:0]          data2_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [WIDTH-1:0]          m_axis_tdata_o;
    logic                      m_axis_tvalid_o;
    logic                      m_axis_tlast_o;
    logic                      m_axis_tready_i;
    logic [$clog2(DEPTH):0]    count_o;

    modport master (
        input  data1_i, data2_i, valid_i, m_axis_tready_i,
        output ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, count_o
    );

    modport slave (
        output data1_i, data2_i, valid_i, m_axis_tready_i,
        input  ready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o, count_o
    );
endinterface

// File: rtl/axis_pair_tx.sv
// Buffers (data1,data2) pairs and sends each as a 2-beat AXI-Stream packet.
// Latency: accept on edge N, beat 0 valid after edge N+1; packets back-to-back.
// Backpressure: tready low stalls the held beat; ready_o drops when FIFO is full.
module axis_pair_tx #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    axis_pair_tx_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t                 state, state_d;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [WIDTH-1:0]       op1, op2;
    logic [WIDTH-1:0]       tdata, tdata_d;
    logic                   tvalid, tvalid_d;
    logic                   tlast, tlast_d;
    logic                   push, pop, empty, ready;
    logic [2*WIDTH-1:0]     head;

    assign ready = (count != CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.valid_i && ready;
    assign head  = mem[rd_ptr];

    // Pop decision looks at registered count only, so a push landing in the
    // same cycle as the last-beat handshake is seen one cycle later.
    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        tdata_d  = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (bus.m_axis_tready_i) state_d = BEAT1;
            end
            BEAT1: begin
                if (bus.m_axis_tready_i) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = BEAT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d = (state_d != IDLE);
        tlast_d  = (state_d == BEAT1);
        case (state_d)
            BEAT0:   tdata_d = pop ? head[WIDTH-1:0] : op1;
            BEAT1:   tdata_d = op2;
            default: tdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= '0;
            op1    <= '0;
            op2    <= '0;
        end else begin
            state  <= state_d;
            tvalid <= tvalid_d;
            tlast  <= tlast_d;
            tdata  <= tdata_d;
            if (pop) begin
                op1 <= head[WIDTH-1:0];
                op2 <= head[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {bus.data2_i, bus.data1_i};
    end

    assign bus.ready_o         = ready;
    assign bus.count_o         = count;
    assign bus.m_axis_tdata_o  = tdata;
    assign bus.m_axis_tvalid_o = tvalid;
    assign bus.m_axis_tlast_o  = tlast;
endmodule

// File: tb/tb_axis_pair_tx.sv
// Scoreboard bench for axis_pair_tx: loads pairs, predicts beats, checks order/stall/reset.
module tb_axis_pair_tx;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tready_set = 1'b1;
    logic rand_mode = 1'b0;
    logic rnd_rdy = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   hs = 0;
    logic [W:0] sb [$];
    logic       prev_stall = 1'b0;
    logic [W-1:0] prev_dat = '0;
    logic       prev_last = 1'b0;

    axis_pair_tx_if #(.WIDTH(W), .DEPTH(D)) ifc ();
    axis_pair_tx #(.WIDTH(W), .DEPTH(D)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(ifc));

    always #5 clk = ~clk;
    assign ifc.m_axis_tready_i = rand_mode ? rnd_rdy : tready_set;
    always @(posedge clk) begin
        #1 rnd_rdy = ($urandom_range(0, 2) != 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predicts the handshake at the coming rising edge; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", ifc.m_axis_tvalid_o, 1);
                check("stall_dat", ifc.m_axis_tdata_o, prev_dat);
                check("stall_last", ifc.m_axis_tlast_o, prev_last);
            end
            if (ifc.m_axis_tvalid_o && ifc.m_axis_tready_i) begin
                hs++;
                if (sb.size() == 0) check("unexpected_beat", {ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, 32'hdead);
                else check("beat", {ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, sb.pop_front());
            end
            if (ifc.valid_i && ifc.ready_o) begin
                sb.push_back({1'b0, ifc.data1_i});
                sb.push_back({1'b1, ifc.data2_i});
            end
            prev_stall = ifc.m_axis_tvalid_o && !ifc.m_axis_tready_i;
            prev_dat   = ifc.m_axis_tdata_o;
            prev_last  = ifc.m_axis_tlast_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 0;
        ifc.data1_i = a;
        ifc.data2_i = b;
        ifc.valid_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ifc.ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("load_timeout", 0, 1);
        tick();
        ifc.valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ifc.m_axis_tvalid_o) begin
                done = 1;
                break;
            end
        end
        check("drain", done, 1);
        tick();
    endtask

    initial begin
        int base;
        ifc.data1_i = '0;
        ifc.data2_i = '0;
        ifc.valid_i = 1'b0;
        #3;
        check("rst_vld", ifc.m_axis_tvalid_o, 0);
        check("rst_last", ifc.m_axis_tlast_o, 0);
        check("rst_dat", ifc.m_axis_tdata_o, 0);
        check("rst_cnt", ifc.count_o, 0);
        check("rst_rdy", ifc.ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single pair
        load(8'd4, 8'd9);
        check("sp_cnt1", ifc.count_o, 1);
        @(negedge clk);
        check("sp_idle", ifc.m_axis_tvalid_o, 0);
        @(negedge clk);
        check("sp_b0", {ifc.m_axis_tvalid_o, ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, {2'b10, 8'd4});
        check("sp_cnt0", ifc.count_o, 0);
        @(negedge clk);
        check("sp_b1", {ifc.m_axis_tvalid_o, ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, {2'b11, 8'd9});
        @(negedge clk);
        check("sp_end", ifc.m_axis_tvalid_o, 0);
        tick();

        // backpressure
        tready_set = 1'b0;
        load(8'd13, 8'd13);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {ifc.m_axis_tvalid_o, ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, {2'b10, 8'd13});
        end
        tick();
        tready_set = 1'b1;
        wait_idle();

        // full FIFO, sixth pair refused, drain without bubbles
        tready_set = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(2 * i + 1), 8'(2 * i + 2));
        @(negedge clk);
        check("full_cnt", ifc.count_o, 4);
        check("full_rdy", ifc.ready_o, 0);
        tick();
        ifc.data1_i = 8'd11;
        ifc.data2_i = 8'd12;
        ifc.valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_refuse", ifc.ready_o, 0);
        end
        tick();
        ifc.valid_i = 1'b0;
        tready_set = 1'b1;
        base = hs;
        repeat (10) @(negedge clk);
        tick();
        check("full_burst", hs - base, 10);
        @(negedge clk);
        #1;
        check("full_end_vld", ifc.m_axis_tvalid_o, 0);
        check("full_end_hs", hs - base, 10);
        wait_idle();

        // simultaneous push/pop at the BEAT1 handshake
        tready_set = 1'b0;
        load(8'd21, 8'd22);
        load(8'd23, 8'd24);
        load(8'd25, 8'd26);
        check("pp_cnt2", ifc.count_o, 2);
        tready_set = 1'b1;
        tick();
        ifc.data1_i = 8'd27;
        ifc.data2_i = 8'd28;
        ifc.valid_i = 1'b1;
        tick();
        ifc.valid_i = 1'b0;
        check("pp_cnt_keep", ifc.count_o, 2);
        check("pp_next", {ifc.m_axis_tvalid_o, ifc.m_axis_tlast_o, ifc.m_axis_tdata_o}, {2'b10, 8'd23});
        wait_idle();

        // reset during BEAT1 with 3 pairs buffered
        tready_set = 1'b0;
        for (int i = 0; i < 4; i++) load(8'(40 + i), 8'(50 + i));
        check("mr_cnt3", ifc.count_o, 3);
        tready_set = 1'b1;
        tick();
        tready_set = 1'b0;
        check("mr_beat1", {ifc.m_axis_tvalid_o, ifc.m_axis_tlast_o}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("mr_vld", ifc.m_axis_tvalid_o, 0);
        check("mr_last", ifc.m_axis_tlast_o, 0);
        check("mr_dat", ifc.m_axis_tdata_o, 0);
        check("mr_cnt", ifc.count_o, 0);
        check("mr_rdy", ifc.ready_o, 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        tready_set = 1'b1;
        base = hs;
        repeat (4) tick();
        check("mr_no_stale", hs - base, 0);
        load(8'd5, 8'd2);
        wait_idle();
        check("mr_new_hs", hs - base, 2);

        // random stress
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            load(8'($urandom), 8'($urandom));
        end
        wait_idle();
        rand_mode = 1'b0;
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
